line_span_writer: RTL and testbench

- Consumer end of the line-drawer coordinate stream. Accepts coordinate beats (valid/fill/x/y/lx) and writes pixels or horizontal spans into a linear framebuffer write port.
- Applies backpressure through `oe`, which the line drawer samples as its output enable.
- Clips each beat to the framebuffer bounds and emits one write per clock.

---
 rtl/line_span_writer.sv | 132 +++++++++++++
 tb/tb_line_span_writer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/line_span_writer.sv
// Consumer end of the line-drawer coordinate stream: clips each beat to the
// framebuffer and writes a pixel or horizontal span, one pixel per clock.
module line_span_writer #(
  parameter int CORDW  = 16,
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int ADDRW  = 17,
  parameter int COLRW  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic [COLRW-1:0]        colr,
  input  logic                    in_valid,
  input  logic                    in_fill,
  input  logic signed [CORDW-1:0] in_x,
  input  logic signed [CORDW-1:0] in_y,
  input  logic signed [CORDW-1:0] in_lx,
  output logic                    oe,
  output logic                    busy,
  output logic                    fb_we,
  output logic [ADDRW-1:0]        fb_addr,
  output logic [COLRW-1:0]        fb_colr
);

  typedef enum logic [1:0] {IDLE, SETUP, WRITE} state_t;

  localparam logic signed [CORDW:0] W_S    = (CORDW+1)'(WIDTH);
  localparam logic signed [CORDW:0] WMAX_S = (CORDW+1)'(WIDTH - 1);
  localparam logic signed [CORDW:0] H_S    = (CORDW+1)'(HEIGHT);
  localparam logic [ADDRW-1:0]      W_A    = ADDRW'(WIDTH);

  state_t                  state_q;
  logic [COLRW-1:0]        colr_q;
  logic signed [CORDW-1:0] y_q, xs_q, xe_q;
  logic [CORDW-1:0]        cnt_q;
  logic                    busy_q, fb_we_q;
  logic [ADDRW-1:0]        fb_addr_q;
  logic [COLRW-1:0]        fb_colr_q;

  logic                    accept_s, span_s, reject_s;
  logic signed [CORDW-1:0] lo_s, hi_s, xs_d, xe_d;
  logic signed [CORDW:0]   y_e_s, xs_e_s, xe_e_s, xs_c_s, xe_c_s;
  logic [CORDW-1:0]        cnt_d;
  logic [ADDRW-1:0]        addr_d;

  // oe must stay independent of every in_* input to avoid a loop through the producer
  assign oe      = (state_q == IDLE) && !rst;
  assign busy    = busy_q;
  assign fb_we   = fb_we_q;
  assign fb_addr = fb_addr_q;
  assign fb_colr = fb_colr_q;

  // Span endpoints at accept, and sign-extended clip/reject/address math for SETUP
  always_comb begin
    accept_s = in_valid && oe;
    span_s   = !mode || in_fill;
    lo_s     = (in_lx < in_x) ? in_lx : in_x;
    hi_s     = (in_lx < in_x) ? in_x : in_lx;
    xs_d     = mode ? lo_s : in_x;
    xe_d     = mode ? hi_s : in_x;

    y_e_s    = {y_q[CORDW-1], y_q};
    xs_e_s   = {xs_q[CORDW-1], xs_q};
    xe_e_s   = {xe_q[CORDW-1], xe_q};
    reject_s = y_e_s[CORDW] || (y_e_s >= H_S) || xe_e_s[CORDW] || (xs_e_s >= W_S);
    xs_c_s   = xs_e_s[CORDW] ? {(CORDW+1){1'b0}} : xs_e_s;
    xe_c_s   = (xe_e_s > WMAX_S) ? WMAX_S : xe_e_s;
    cnt_d    = CORDW'(xe_c_s - xs_c_s);
    addr_d   = ADDRW'(y_q) * W_A + ADDRW'(xs_c_s);
  end

  // Control FSM with registered framebuffer outputs; reset aborts any span in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      colr_q    <= {COLRW{1'b0}};
      y_q       <= {CORDW{1'b0}};
      xs_q      <= {CORDW{1'b0}};
      xe_q      <= {CORDW{1'b0}};
      cnt_q     <= {CORDW{1'b0}};
      busy_q    <= 1'b0;
      fb_we_q   <= 1'b0;
      fb_addr_q <= {ADDRW{1'b0}};
      fb_colr_q <= {COLRW{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          fb_we_q <= 1'b0;
          if (accept_s && span_s) begin
            colr_q  <= colr;
            y_q     <= in_y;
            xs_q    <= xs_d;
            xe_q    <= xe_d;
            busy_q  <= 1'b1;
            state_q <= SETUP;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        SETUP: begin
          if (reject_s) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q     <= cnt_d;
            fb_addr_q <= addr_d;
            fb_colr_q <= colr_q;
            fb_we_q   <= 1'b1;
            state_q   <= WRITE;
          end
        end
        WRITE: begin
          if (cnt_q == {CORDW{1'b0}}) begin
            fb_we_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            fb_addr_q <= fb_addr_q + ADDRW'(1);
            cnt_q     <= cnt_q - CORDW'(1);
          end
        end
        default: begin
          fb_we_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_span_writer.sv
// Directed bench for line_span_writer: expected writes are queued as beats are
// driven and popped by a monitor whenever the DUT asserts fb_we.
module tb_line_span_writer;

  logic               clk = 1'b0;
  logic               rst;
  logic               mode;
  logic [3:0]         colr;
  logic               in_valid;
  logic               in_fill;
  logic signed [15:0] in_x, in_y, in_lx;
  logic               oe, busy, fb_we;
  logic [16:0]        fb_addr;
  logic [3:0]         fb_colr;

  logic [20:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int writes = 0;
  int n_low, w0;

  line_span_writer dut (
    .clk(clk), .rst(rst), .mode(mode), .colr(colr),
    .in_valid(in_valid), .in_fill(in_fill),
    .in_x(in_x), .in_y(in_y), .in_lx(in_lx),
    .oe(oe), .busy(busy), .fb_we(fb_we), .fb_addr(fb_addr), .fb_colr(fb_colr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every write must match the oldest queued expectation
  task automatic monitor();
    logic [20:0] e;
    forever begin
      @(negedge clk);
      if (fb_we === 1'b1) begin
        writes++;
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_write observed addr=%0d expected no write", fb_addr);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checks++;
          assert ({fb_addr, fb_colr} === e) else begin
            errors++;
            $error("FAIL write observed addr=%0d colr=%0d expected addr=%0d colr=%0d",
                   fb_addr, fb_colr, e[20:4], e[3:0]);
          end
        end
      end
    end
  endtask

  task automatic push_span(input int a0, input int n, input logic [3:0] c);
    for (int i = 0; i < n; i++) exp_q.push_back({17'(a0 + i), c});
  endtask

  // Waits (bounded) for oe, then presents one beat; returns #1 after the accept edge
  task automatic beat(input logic m, input logic f, input int x, input int y,
                      input int lx, input logic [3:0] c);
    int n = 0;
    while (oe !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("oe_ready", int'(oe), 1);
    mode = m; in_fill = f; colr = c;
    in_x = 16'(x); in_y = 16'(y); in_lx = 16'(lx);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic oe_low(output int n);
    n = 0;
    while (oe !== 1'b1 && n < 64) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; colr = 4'd0; in_valid = 1'b0; in_fill = 1'b0;
    in_x = 16'sd0; in_y = 16'sd0; in_lx = 16'sd0;
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1;
    chk("rst_oe", int'(oe), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_we", int'(fb_we), 0);
    chk("rst_addr", int'(fb_addr), 0);
    chk("rst_colr", int'(fb_colr), 0);
    rst = 1'b0;
    #1;
    chk("oe_after_rst", int'(oe), 1);

    // single plot, mode 0
    w0 = writes; push_span(323, 1, 4'd5);
    beat(1'b0, 1'b0, 3, 1, 0, 4'd5);
    oe_low(n_low);
    chk("plot_oe_low", n_low, 2);
    chk("plot_writes", writes - w0, 1);

    // fill span, with first-write latency check
    w0 = writes; push_span(650, 5, 4'd9);
    beat(1'b1, 1'b1, 14, 2, 10, 4'd9);
    chk("span_setup_busy", int'(busy), 1);
    chk("span_setup_we", int'(fb_we), 0);
    @(posedge clk); #1;
    chk("span_first_we", int'(fb_we), 1);
    chk("span_first_addr", int'(fb_addr), 650);
    oe_low(n_low);
    chk("span_oe_low", n_low + 1, 6);
    chk("span_writes", writes - w0, 5);

    // reversed endpoints
    w0 = writes; push_span(650, 5, 4'd3);
    beat(1'b1, 1'b1, 10, 2, 14, 4'd3);
    oe_low(n_low);
    chk("rev_oe_low", n_low, 6);
    chk("rev_writes", writes - w0, 5);

    // non-fill beat in mode 1 is consumed silently
    w0 = writes;
    beat(1'b1, 1'b0, 40, 7, 30, 4'd1);
    chk("nofill_oe", int'(oe), 1);
    chk("nofill_busy", int'(busy), 0);
    repeat (3) @(posedge clk); #1;
    chk("nofill_writes", writes - w0, 0);

    // left clip
    w0 = writes; push_span(0, 3, 4'd4);
    beat(1'b1, 1'b1, 2, 0, -3, 4'd4);
    oe_low(n_low);
    chk("lclip_oe_low", n_low, 4);
    chk("lclip_writes", writes - w0, 3);

    // right clip on the last row
    w0 = writes; push_span(76797, 3, 4'd12);
    beat(1'b1, 1'b1, 330, 239, 317, 4'd12);
    oe_low(n_low);
    chk("rclip_oe_low", n_low, 4);
    chk("rclip_writes", writes - w0, 3);

    // rejects: below bottom, entirely left, entirely right
    w0 = writes;
    beat(1'b0, 1'b0, 5, 240, 0, 4'd2);
    oe_low(n_low);
    chk("rej_y_oe_low", n_low, 1);
    beat(1'b1, 1'b1, -1, 3, -5, 4'd2);
    oe_low(n_low);
    chk("rej_xe_oe_low", n_low, 1);
    beat(1'b0, 1'b0, 320, 0, 0, 4'd2);
    oe_low(n_low);
    chk("rej_xs_oe_low", n_low, 1);
    chk("rej_writes", writes - w0, 0);

    // reset during the third write of a 10-pixel span
    w0 = writes; push_span(1280, 3, 4'd7);
    beat(1'b1, 1'b1, 9, 4, 0, 4'd7);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_we", int'(fb_we), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_oe", int'(oe), 0);
    rst = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("abort_writes", writes - w0, 3);
    chk("abort_queue", exp_q.size(), 0);
    w0 = writes; push_span(1607, 1, 4'd2);
    beat(1'b0, 1'b0, 7, 5, 0, 4'd2);
    oe_low(n_low);
    chk("post_rst_oe_low", n_low, 2);
    chk("post_rst_writes", writes - w0, 1);

    // drawer pixel stream for (0,0)-(4,2), producer stalled by oe
    w0 = writes;
    push_span(0, 1, 4'd6); push_span(321, 1, 4'd6); push_span(322, 1, 4'd6);
    push_span(643, 1, 4'd6); push_span(644, 1, 4'd6);
    beat(1'b0, 1'b0, 0, 0, 0, 4'd6);
    beat(1'b0, 1'b0, 1, 1, 0, 4'd6);
    beat(1'b0, 1'b0, 2, 1, 0, 4'd6);
    beat(1'b0, 1'b0, 3, 2, 0, 4'd6);
    beat(1'b0, 1'b0, 4, 2, 0, 4'd6);
    oe_low(n_low);
    chk("line_writes", writes - w0, 5);

    repeat (3) @(posedge clk); #1;
    chk("final_queue", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
